if_prefetch_unit: RTL

//  Parametrised instruction-fetch stage with a decoupled prefetch buffer. It generates sequential

---
 rtl/if_pkg.sv | 13 +
 rtl/if_prefetch_fifo.sv | 48 ++++
 rtl/if_prefetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; pointers and count clear on async reset.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  input  logic          flush,
  output entry_t        rdata,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch stage: sequential address generation, in-order response buffering, redirect squash.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d, discard_q, discard_d;
  logic [CW-1:0]   count;
  logic [CW:0]     in_use;
  logic [XLEN-1:0] target;
  logic            req_fire, resp_fire, push, pop;
  entry_t          head;

  assign in_use    = {1'b0, count} + {1'b0, outstanding_q};
  assign target    = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
  // Reset gating keeps the request low while the counters are held clear.
  assign imem_req_valid = !reset && !redirect_valid && (in_use < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_fire = imem_resp_valid && (outstanding_q != '0);
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    push          = 1'b0;
    if (redirect_valid) begin
      // Every request still in flight after this cycle belongs to the wrong path.
      fetch_pc_d    = target;
      resp_pc_d     = target;
      outstanding_d = outstanding_q - CW'(resp_fire);
      discard_d     = outstanding_q - CW'(resp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);
      if (resp_fire) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ('{pc: resp_pc_q, instr: imem_resp_data}),
    .pop   (pop),
    .flush (redirect_valid),
    .rdata (head),
    .count (count)
  );

endmodule
